// File: rtl/jtframe_sram_arb.sv
// Two-port arbiter/sequencer for an external asynchronous 16-bit SRAM.
// Registered strobes, WAIT-cycle accesses, one bus-release cycle between accesses.
module jtframe_sram_arb #(
  parameter int AW   = 21,
  parameter int DW   = 16,
  parameter int WAIT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [1:0]    dsn0,
  input  logic [1:0]    dsn1,
  output logic [1:0]    ack,
  output logic [DW-1:0] dout,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_dout,
  output logic          sram_doe,
  input  logic [DW-1:0] sram_din,
  output logic          sram_we_n,
  output logic          sram_oe_n,
  output logic          sram_ub_n,
  output logic          sram_lb_n
);

  localparam int CW = (WAIT > 1) ? $clog2(WAIT) + 1 : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            gnt_q, gnt_d;
  logic            wr_q, wr_d;
  logic [1:0]      ack_q, ack_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   sdout_q, sdout_d;
  logic            doe_q, doe_d;
  logic            we_n_q, we_n_d;
  logic            oe_n_q, oe_n_d;
  logic            ub_n_q, ub_n_d;
  logic            lb_n_q, lb_n_d;

  // On a tie the port that did not go last wins, so steady contention alternates.
  logic       sel;
  logic       sel_we;
  logic [1:0] sel_dsn;
  assign sel     = (req == 2'b11) ? ~last_q : req[1];
  assign sel_we  = sel ? we[1] : we[0];
  assign sel_dsn = sel ? dsn1 : dsn0;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    ack_d   = 2'b00;
    dout_d  = dout_q;
    addr_d  = addr_q;
    sdout_d = sdout_q;
    doe_d   = doe_q;
    we_n_d  = we_n_q;
    oe_n_d  = oe_n_q;
    ub_n_d  = ub_n_q;
    lb_n_d  = lb_n_q;
    case (state_q)
      IDLE: if (|req) begin
        gnt_d   = sel;
        last_d  = sel;
        wr_d    = sel_we;
        addr_d  = sel ? addr1 : addr0;
        sdout_d = sel ? din1 : din0;
        ub_n_d  = sel_dsn[1];
        lb_n_d  = sel_dsn[0];
        we_n_d  = ~sel_we;
        oe_n_d  = sel_we;
        doe_d   = sel_we;
        cnt_d   = CW'(WAIT - 1);
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          ack_d  = gnt_q ? 2'b10 : 2'b01;
          if (!wr_q) dout_d = sram_din;
          we_n_d = 1'b1;
          oe_n_d = 1'b1;
          ub_n_d = 1'b1;
          lb_n_d = 1'b1;
          doe_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= 2'b00;
      dout_q  <= '0;
      addr_q  <= '0;
      sdout_q <= '0;
      doe_q   <= 1'b0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      sdout_q <= sdout_d;
      doe_q   <= doe_d;
      we_n_q  <= we_n_d;
      oe_n_q  <= oe_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
    end
  end

  assign ack       = ack_q;
  assign dout      = dout_q;
  assign sram_addr = addr_q;
  assign sram_dout = sdout_q;
  assign sram_doe  = doe_q;
  assign sram_we_n = we_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_ub_n = ub_n_q;
  assign sram_lb_n = lb_n_q;

endmodule

// File: doc/jtframe_sram_arb.md
Name: jtframe_sram_arb

Overview:
- Two-port arbiter and sequencer for the board's external asynchronous 16-bit SRAM (21-bit word address, UB/LB byte lanes, active-low WE/OE).
- Shares the SRAM between two requesters, e.g. the line-frame buffer writer (port 0) and the frame scan-out reader (port 1), or the game core and the frame buffer.
- Sits between the requesters and the top-level SRAM pins; the top level builds the tristate bus from sram_dout/sram_doe/sram_din.

Parameters:
- AW, 21, SRAM word address width.
- DW, 16, SRAM data width.
- WAIT, 2, cycles the address and strobes are held per access; must be ≥ 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  2  per-port request level; bit n is port n.
- we  in  2  per-port write (1) / read (0); sampled at grant.
- addr0, addr1  in  AW  per-port word address.
- din0, din1  in  DW  per-port write data.
- dsn0, dsn1  in  2  per-port active-low byte enables; [1] is the upper byte.
- ack  out  2  one-cycle completion pulse per port.
- dout  out  DW  read data, valid in the ack cycle and held until the next read completes.
- sram_addr  out  AW  SRAM address.
- sram_dout  out  DW  data driven to the SRAM.
- sram_doe  out  1  data drive enable; 1 drives the bus.
- sram_din  in  DW  data from the SRAM.
- sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active low.

Behaviour:
- States:
  - IDLE: strobes inactive; waiting for a request.
  - ACCESS: an access is in progress.
  - RECOVER: one cycle with the bus released and all strobes high.
- Reset (rst_n low at an edge): state=IDLE, ack=0, dout=0, sram_addr=0, sram_dout=0, sram_doe=0, all *_n=1, last=1 (port 0 wins the first tie).
  - Reset during ACCESS or RECOVER aborts immediately; no ack is issued.
- IDLE, at an edge with any req bit high:
  - Grant one port. If only one port requests, grant it. If both request, grant the port that is not `last`.
  - Register the granted port's addr, dsn, din and we into the SRAM outputs: sram_ub_n=dsn[1], sram_lb_n=dsn[0].
  - Write: sram_we_n=0, sram_oe_n=1, sram_doe=1.
  - Read: sram_oe_n=0, sram_we_n=1, sram_doe=0.
  - Load counter=WAIT-1, set last=granted port, go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - Outputs are frozen. Requester input changes after the grant are ignored, including req dropping early; the access completes and ack is still pulsed.
  - If counter≠0, decrement it.
  - If counter=0 at an edge:
    - Pulse ack[granted] for exactly one cycle.
    - If read, capture sram_din into dout.
    - Drive sram_we_n=sram_oe_n=sram_ub_n=sram_lb_n=1 and sram_doe=0.
    - sram_addr keeps its value.
    - Go to RECOVER.
- RECOVER: ack returns to 0, go to IDLE.
  - req is ignored in this cycle. This absorbs the requester's registered req drop after it sees ack, so one request never produces two accesses.
- Timing:
  - Grant edge is G.
  - ack is high in the cycle after edge G+WAIT.
  - Strobes are active for WAIT cycles.
  - Access-to-access period is WAIT+2 cycles.
- Handshake:
  - A requester holds req, addr, din, dsn and we stable until it sees ack, then drops req or presents a new request.
  - A held req after RECOVER means a new access.
- Fairness:
  - With both ports continuously requesting, grants alternate 0,1,0,1…
  - No port waits longer than one foreign access plus RECOVER.
- No write/read bus contention: sram_doe and sram_oe_n are never both active, and there is always one RECOVER cycle between accesses.
- dsn=2'b11 still performs a full-length cycle with both byte lanes disabled, then acks.

Test Plan:
1. Reset, then req=01, we0=1, addr0=0x00010, din0=0xA5C3, dsn0=00, WAIT=2 → sram_we_n low for 2 cycles with addr 0x00010 and data 0xA5C3, sram_doe=1; ack[0] pulses one cycle; sram_we_n is high for the RECOVER cycle.
2. Read on port 1 from addr1=0x1FFFFF with sram_din model returning 0x1234 → sram_oe_n low for 2 cycles; dout=0x1234 in the ack[1] cycle; sram_doe stays 0 throughout.
3. Both ports request continuously from reset → grant order 0,1,0,1; ack pulses every 4 cycles (WAIT+2); no double access on a req held one cycle after ack.
4. Write with dsn0=10 → sram_ub_n=1, sram_lb_n=0 during ACCESS; both return to 1 in RECOVER.
5. rst_n low in the second ACCESS cycle of a write → next cycle all strobes high, sram_doe=0, no ack; after release, port 0 wins a tie.
6. WAIT=1 with req1 dropped during ACCESS → access still completes; ack[1] occurs 1 cycle after grant; IDLE follows RECOVER with no new grant.
